// File: rtl/ads8556_pkg.sv
// Shared encodings for the ADS8556 device-side responder.
package ads8556_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_STBY = 2'd2
  } state_e;

  localparam int CHNL_NUM = 6;
  localparam int PTR_W    = $clog2(CHNL_NUM);

  typedef enum logic {
    WSEL_HIGH = 1'b0,
    WSEL_LOW  = 1'b1
  } wsel_e;

  localparam int CSN_IDLE_RST = 8;
  localparam int CSN_CNT_W    = $clog2(CSN_IDLE_RST + 1);

  // Channel read pointer walks ch0..ch5 and wraps.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CHNL_NUM - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous host strobe, with a delay flop
// producing registered rise/fall pulses aligned to the level output.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    dly_d  = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~dly_q;
    fall_d = ~sync_q[STAGES-1] & dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = dly_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ads8556_emu.sv
// Device-side ADS8556 parallel-port responder: conversion timing, six-channel
// sample readout and two-word configuration capture.
module ads8556_emu
  import ads8556_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int CONV_CYCLES = 140,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ads8556_conv,
  input  logic        ads8556_csn,
  input  logic        ads8556_rdn,
  input  logic        ads8556_wrn,
  input  logic        ads8556_standbyn,
  input  logic        ads8556_reset,
  output logic        ads8556_busy,
  input  logic [15:0] ads8556_data_in,
  output logic [15:0] ads8556_data_out,
  output logic        ads8556_data_t,
  input  logic [15:0] sample_ch0,
  input  logic [15:0] sample_ch1,
  input  logic [15:0] sample_ch2,
  input  logic [15:0] sample_ch3,
  input  logic [15:0] sample_ch4,
  input  logic [15:0] sample_ch5,
  output logic [31:0] cfg_reg,
  output logic        cfg_valid,
  output logic [15:0] conv_count
);

  localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam int I_CONV = 0, I_CSN = 1, I_RDN = 2, I_WRN = 3, I_STBY = 4, I_RST = 5;
  // Idle pin levels so that releasing rst never looks like a host edge.
  localparam logic [5:0] SYNC_INIT = 6'b011110;

  logic [5:0] pins, lvl, rise, fall;
  assign pins = {ads8556_reset, ads8556_standbyn, ads8556_wrn,
                 ads8556_rdn, ads8556_csn, ads8556_conv};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_INIT[g])) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (pins[g]),
      .level(lvl[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  logic [CHNL_NUM-1:0][15:0] samples;
  assign samples = {sample_ch5, sample_ch4, sample_ch3, sample_ch2, sample_ch1, sample_ch0};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [CHNL_NUM-1:0][15:0] shadow_q, shadow_d;
  logic [CHNL_NUM-1:0][15:0] latch_q, latch_d;
  logic [15:0]               conv_count_q, conv_count_d;
  logic [31:0]               cfg_q, cfg_d;
  logic                      cfg_valid_q, cfg_valid_d;
  wsel_e                     wsel_q, wsel_d;
  logic [CSN_CNT_W-1:0]      csn_idle_q, csn_idle_d;
  logic                      rd_wr_q, rd_wr_d;
  logic [15:0]               wr_data_q, wr_data_d;
  logic [15:0]               data_out_q, data_out_d;
  logic                      data_t_q, data_t_d;
  logic                      rd_drive;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    ptr_d        = ptr_q;
    shadow_d     = shadow_q;
    latch_d      = latch_q;
    conv_count_d = conv_count_q;
    cfg_d        = cfg_q;
    cfg_valid_d  = 1'b0;
    wsel_d       = wsel_q;
    csn_idle_d   = csn_idle_q;
    rd_wr_d      = rd_wr_q;
    wr_data_d    = wr_data_q;
    data_out_d   = data_out_q;

    // A concurrent write strobe keeps the bus released.
    rd_drive = ~lvl[I_CSN] & ~lvl[I_RDN] & lvl[I_WRN] & (state_q != ST_STBY);
    data_t_d = ~rd_drive;
    if (rd_drive) data_out_d = latch_q[ptr_q];

    // Remember an overlapping write so the closing rdn edge does not advance.
    if (~lvl[I_RDN] & ~lvl[I_WRN]) rd_wr_d = 1'b1;
    else if (rise[I_RDN] | rise[I_CSN] | fall[I_RDN]) rd_wr_d = 1'b0;

    if (rise[I_RDN] & ~lvl[I_CSN] & lvl[I_WRN] & ~rd_wr_q & (state_q != ST_STBY))
      ptr_d = ptr_next(ptr_q);

    if (~lvl[I_WRN]) wr_data_d = ads8556_data_in;
    if (rise[I_WRN] & ~lvl[I_CSN]) begin
      if (wsel_q == WSEL_HIGH) begin
        cfg_d[31:16] = wr_data_q;
        wsel_d       = WSEL_LOW;
      end else begin
        cfg_d[15:0]  = wr_data_q;
        cfg_valid_d  = 1'b1;
        wsel_d       = WSEL_HIGH;
      end
    end

    if (~lvl[I_CSN]) csn_idle_d = '0;
    else if (csn_idle_q != CSN_CNT_W'(CSN_IDLE_RST)) csn_idle_d = csn_idle_q + CSN_CNT_W'(1);
    if (lvl[I_CSN] && csn_idle_q >= CSN_CNT_W'(CSN_IDLE_RST - 1)) wsel_d = WSEL_HIGH;

    // Samples are taken at conv but only become readable once the conversion ends.
    case (state_q)
      ST_IDLE: if (rise[I_CONV]) begin
        shadow_d = samples;
        cnt_d    = CNT_W'(CONV_CYCLES - 1);
        busy_d   = 1'b1;
        state_d  = ST_CONV;
      end
      ST_CONV: if (cnt_q == '0) begin
        busy_d       = 1'b0;
        ptr_d        = '0;
        latch_d      = shadow_q;
        conv_count_d = conv_count_q + 16'd1;
        state_d      = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_STBY: if (lvl[I_STBY]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (~lvl[I_STBY]) begin
      state_d = ST_STBY;
      busy_d  = 1'b0;
    end

    if (lvl[I_RST] | rise[I_RST]) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      busy_d       = 1'b0;
      ptr_d        = '0;
      shadow_d     = '0;
      latch_d      = '0;
      conv_count_d = '0;
      cfg_d        = '0;
      cfg_valid_d  = 1'b0;
      wsel_d       = WSEL_HIGH;
      rd_wr_d      = 1'b0;
      data_out_d   = '0;
      data_t_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      ptr_q        <= '0;
      shadow_q     <= '0;
      latch_q      <= '0;
      conv_count_q <= '0;
      cfg_q        <= '0;
      cfg_valid_q  <= 1'b0;
      wsel_q       <= WSEL_HIGH;
      csn_idle_q   <= '0;
      rd_wr_q      <= 1'b0;
      wr_data_q    <= '0;
      data_out_q   <= '0;
      data_t_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      shadow_q     <= shadow_d;
      latch_q      <= latch_d;
      conv_count_q <= conv_count_d;
      cfg_q        <= cfg_d;
      cfg_valid_q  <= cfg_valid_d;
      wsel_q       <= wsel_d;
      csn_idle_q   <= csn_idle_d;
      rd_wr_q      <= rd_wr_d;
      wr_data_q    <= wr_data_d;
      data_out_q   <= data_out_d;
      data_t_q     <= data_t_d;
    end
  end

  assign ads8556_busy     = busy_q;
  assign ads8556_data_out = data_out_q;
  assign ads8556_data_t   = data_t_q;
  assign cfg_reg          = cfg_q;
  assign cfg_valid        = cfg_valid_q;
  assign conv_count       = conv_count_q;

endmodule

// File: tb/tb_ads8556_emu.sv
// Randomized self-checking bench for ads8556_emu against a transaction-level model.
module tb_ads8556_emu;

  logic        clk = 1'b0, rst = 1'b1;
  logic        conv = 1'b0, csn = 1'b1, rdn = 1'b1, wrn = 1'b1, standbyn = 1'b1, dev_rst = 1'b0;
  logic        busy, data_t, cfg_valid;
  logic [15:0] data_in = '0, data_out, conv_count;
  logic [15:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0, ch5 = '0;
  logic [31:0] cfg_reg;

  always #5 clk = ~clk;

  ads8556_emu #(.CLK_FREQ(100_000_000), .CONV_CYCLES(140), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .ads8556_conv(conv), .ads8556_csn(csn), .ads8556_rdn(rdn), .ads8556_wrn(wrn),
    .ads8556_standbyn(standbyn), .ads8556_reset(dev_rst), .ads8556_busy(busy),
    .ads8556_data_in(data_in), .ads8556_data_out(data_out), .ads8556_data_t(data_t),
    .sample_ch0(ch0), .sample_ch1(ch1), .sample_ch2(ch2),
    .sample_ch3(ch3), .sample_ch4(ch4), .sample_ch5(ch5),
    .cfg_reg(cfg_reg), .cfg_valid(cfg_valid), .conv_count(conv_count)
  );

  int n_vec = 0, n_err = 0;
  int vpulse = 0;
  always @(posedge clk) if (cfg_valid === 1'b1) vpulse <= vpulse + 1;

  // Reference model: what the host should see, tracked per transaction.
  logic [15:0] m_smp[6];
  logic [15:0] m_vis[6];
  int          m_ptr = 0;
  logic [31:0] m_cfg = '0;
  bit          m_low = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_vis[i] = '0;
    m_ptr = 0; m_cfg = '0; m_low = 1'b0; m_cnt = '0;
  endtask

  task automatic set_samples();
    ch0 = m_smp[0]; ch1 = m_smp[1]; ch2 = m_smp[2];
    ch3 = m_smp[3]; ch4 = m_smp[4]; ch5 = m_smp[5];
  endtask

  task automatic conv_commit();
    for (int i = 0; i < 6; i++) m_vis[i] = m_smp[i];
    m_ptr = 0;
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic do_conv();
    int n;
    conv = 1'b1; cyc(10); conv = 1'b0;
    chk("busy_up", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin cyc(1); n++; end
    chk("conv_end", busy, 0);
    conv_commit();
    chk("conv_cnt", conv_count, m_cnt);
  endtask

  task automatic do_read();
    logic [15:0] e;
    e = m_vis[m_ptr];
    chk("rd_pre_t", data_t, 1);
    rdn = 1'b0; cyc(6);
    chk("rd_t", data_t, 0);
    chk("rd_data", data_out, e);
    rdn = 1'b1; cyc(6);
    chk("rd_rel_t", data_t, 1);
    chk("rd_hold", data_out, e);
    m_ptr = (m_ptr + 1) % 6;
  endtask

  task automatic model_write(input logic [15:0] w);
    if (!m_low) m_cfg[31:16] = w; else m_cfg[15:0] = w;
    m_low = !m_low;
  endtask

  task automatic do_write(input logic [15:0] w);
    int p0;
    bit low;
    p0 = vpulse; low = m_low;
    data_in = w; wrn = 1'b0; cyc(6); wrn = 1'b1; cyc(6);
    model_write(w);
    chk("cfg", cfg_reg, m_cfg);
    chk("cfg_vld", vpulse - p0, {31'd0, low});
  endtask

  task automatic do_rdwr(input logic [15:0] w);
    data_in = w; rdn = 1'b0; wrn = 1'b0; cyc(6);
    chk("rdwr_t", data_t, 1);
    rdn = 1'b1; wrn = 1'b1; cyc(6);
    model_write(w);
    chk("rdwr_cfg", cfg_reg, m_cfg);
  endtask

  task automatic csn_release();
    csn = 1'b1; cyc(20);
    m_low = 1'b0;
  endtask

  initial begin
    int n, w, nr, nw;
    logic [15:0] a, b;
    model_reset();
    for (int i = 0; i < 6; i++) m_smp[i] = 16'h1111 * 16'(i + 1);
    set_samples();
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_t", data_t, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_cfg", cfg_reg, 0);
    chk("rst_vld", cfg_valid, 0);
    chk("rst_cnt", conv_count, 0);
    rst = 1'b0; cyc(3);

    // Conversion timing: 100 ns conv pulse, busy latency and width.
    conv = 1'b1; n = 0;
    do begin cyc(1); n++; end while (busy !== 1'b1 && n < 20);
    chk("busy_lat", n - 1, 3);
    w = 0;
    while (busy === 1'b1 && w < 1000) begin
      cyc(1); w++;
      if (n + w >= 10) conv = 1'b0;
    end
    conv = 1'b0;
    chk("busy_width", w, 140);
    conv_commit();
    chk("cnt_1", conv_count, 1);

    // Sample readout including wrap on the seventh read.
    csn = 1'b0; cyc(1);
    for (int i = 0; i < 7; i++) do_read();
    chk("rd7_ch0", data_out, 16'h1111);

    // Config pair.
    csn_release(); csn = 1'b0; cyc(1);
    do_write(16'hFC00);
    do_write(16'h03FF);
    chk("cfg_plan", cfg_reg, 32'hFC0003FF);

    // Conv mid-conversion ignored, reads during busy see previous data.
    fork
      begin
        n = 0;
        while (busy !== 1'b1 && n < 20) begin cyc(1); n++; end
        w = 0;
        while (busy === 1'b1 && w < 1000) begin cyc(1); w++; end
      end
      begin
        conv = 1'b1; cyc(10); conv = 1'b0; cyc(20);
        ch0 = 16'hAAAA;
        conv = 1'b1; cyc(10); conv = 1'b0; cyc(5);
        do_read();
      end
    join
    chk("restart_width", w, 140);
    conv_commit();
    chk("restart_cnt", conv_count, m_cnt);
    do_read();
    set_samples();

    // Read and write overlapping: write wins, pointer holds.
    do_rdwr(16'($urandom));
    do_read();

    // Randomized rounds.
    csn_release();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) m_smp[i] = 16'($urandom);
      set_samples();
      do_conv();
      csn = 1'b0; cyc(1);
      nr = $urandom_range(1, 8);
      for (int i = 0; i < nr; i++) do_read();
      nw = $urandom_range(1, 2);
      for (int i = 0; i < nw; i++) do_write(16'($urandom));
      csn_release();
    end

    // Lone high word, then csn idle realigns word select.
    csn = 1'b0; cyc(1);
    do_write(16'h1234);
    csn_release(); csn = 1'b0; cyc(1);
    a = 16'($urandom); b = 16'($urandom);
    do_write(a); do_write(b);
    chk("cfg_realign", cfg_reg, {a, b});

    // Standby aborts conversion and blocks conv.
    for (int i = 0; i < 6; i++) m_smp[i] = 16'($urandom);
    set_samples();
    conv = 1'b1; cyc(10); conv = 1'b0; cyc(10);
    chk("stby_pre", busy, 1);
    standbyn = 1'b0; n = 0;
    while (busy === 1'b1 && n < 10) begin cyc(1); n++; end
    chk("stby_lat", {31'd0, n <= 4}, 1);
    conv = 1'b1; cyc(10); conv = 1'b0; cyc(10);
    chk("stby_conv", busy, 0);
    chk("stby_cnt", conv_count, m_cnt);
    standbyn = 1'b1; cyc(6);
    do_read();

    // Device reset pin, with word select left at LOW beforehand.
    do_write(16'h5A5A);
    dev_rst = 1'b1; cyc(8);
    chk("drst_cfg", cfg_reg, 0);
    chk("drst_cnt", conv_count, 0);
    chk("drst_busy", busy, 0);
    chk("drst_t", data_t, 1);
    dev_rst = 1'b0; cyc(6);
    model_reset();
    a = 16'($urandom); b = 16'($urandom);
    do_write(a); do_write(b);
    chk("drst_wsel", cfg_reg, {a, b});
    do_read();

    // Asynchronous rst mid-read during a conversion.
    conv = 1'b1; cyc(10); conv = 1'b0;
    rdn = 1'b0; cyc(6);
    chk("arst_pre_t", data_t, 0);
    chk("arst_pre_b", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_t", data_t, 1);
    chk("arst_busy", busy, 0);
    chk("arst_cfg", cfg_reg, 0);
    rdn = 1'b1; csn = 1'b1;
    cyc(4); rst = 1'b0; cyc(4);
    chk("arst_cnt", conv_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
